// File: rtl/axi_llc_pkg.sv
// Shared types for the LLC tag SRAM controller: FSM states and response-pipeline stage.
package axi_llc_pkg;

   localparam int unsigned MaxPorts = 8;
   localparam int unsigned PortIdxW = $clog2(MaxPorts);

   typedef enum logic [0:0] {
      StInit = 1'b0,
      StIdle = 1'b1
   } state_e;

   typedef struct packed {
      logic                valid;
      logic                read;
      logic [PortIdxW-1:0] port;
   } resp_stage_t;

endpackage

// File: rtl/tc_sram.sv
// Behavioural single-port SRAM with byte-masked writes and a Latency-deep read pipeline.
module tc_sram #(
   parameter int unsigned NumWords  = 1024,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned NumPorts  = 1,
   parameter int unsigned Latency   = 1
) (
   input  logic                                       clk_i,
   input  logic [NumPorts-1:0]                        req_i,
   input  logic [NumPorts-1:0]                        we_i,
   input  logic [NumPorts*$clog2(NumWords)-1:0]       addr_i,
   input  logic [NumPorts*DataWidth-1:0]              wdata_i,
   input  logic [NumPorts*((DataWidth+7)/8)-1:0]      be_i,
   output logic [NumPorts*DataWidth-1:0]              rdata_o
);

   localparam int unsigned AddrW = $clog2(NumWords);

   logic [DataWidth-1:0] mem_q   [NumWords];
   logic [DataWidth-1:0] rdata_q [Latency];
   logic [DataWidth-1:0] bit_mask_c;

   // Expand byte enables to a per-bit write mask (last byte may be partial)
   for (genvar i = 0; i < DataWidth; i++) begin : g_mask
      assign bit_mask_c[i] = be_i[i/8];
   end

   // Array write, read capture and read-data pipeline; storage is not reset
   always_ff @(posedge clk_i) begin
      if (req_i[0] && we_i[0]) begin
         mem_q[addr_i[AddrW-1:0]] <= (mem_q[addr_i[AddrW-1:0]] & ~bit_mask_c)
                                     | (wdata_i[DataWidth-1:0] & bit_mask_c);
      end
      if (req_i[0] && !we_i[0]) begin
         rdata_q[0] <= mem_q[addr_i[AddrW-1:0]];
      end
      for (int s = 1; s < Latency; s++) begin
         rdata_q[s] <= rdata_q[s-1];
      end
   end

   // Replicate final pipeline stage to every port slice
   assign rdata_o = {NumPorts{rdata_q[Latency-1]}};

endmodule

// File: rtl/axi_llc_tag_sram_ctrl.sv
// LLC tag SRAM controller: init/flush sweep plus round-robin sharing of one SRAM port.
module axi_llc_tag_sram_ctrl
   import axi_llc_pkg::*;
#(
   parameter int unsigned          NumWords  = 1024,
   parameter int unsigned          DataWidth = 32,
   parameter int unsigned          NumPorts  = 2,
   parameter int unsigned          Latency   = 1,
   parameter logic [DataWidth-1:0] InitValue = '0
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  flush_i,
   output logic                                  busy_o,
   input  logic [NumPorts-1:0]                   req_i,
   output logic [NumPorts-1:0]                   gnt_o,
   input  logic [NumPorts-1:0]                   we_i,
   input  logic [NumPorts*$clog2(NumWords)-1:0]  addr_i,
   input  logic [NumPorts*DataWidth-1:0]         wdata_i,
   input  logic [NumPorts*((DataWidth+7)/8)-1:0] be_i,
   output logic [NumPorts-1:0]                   rvalid_o,
   output logic [NumPorts*DataWidth-1:0]         rdata_o
);

   localparam int unsigned AddrW = $clog2(NumWords);
   localparam int unsigned BeW   = (DataWidth + 7) / 8;
   localparam int unsigned PtrW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;

   state_e               state_q, state_d;
   logic [AddrW-1:0]     cnt_q, cnt_d;
   logic [PtrW-1:0]      ptr_q, ptr_d;
   resp_stage_t          resp_q [Latency];
   resp_stage_t          resp_d [Latency];

   logic                 accept_c;
   logic [PtrW-1:0]      sel_c;
   logic [PtrW-1:0]      cand_c;
   logic                 sel_we_c;
   logic [AddrW-1:0]     sel_addr_c;
   logic [DataWidth-1:0] sel_wdata_c;
   logic [BeW-1:0]       sel_be_c;

   logic                 sram_req_c;
   logic                 sram_we_c;
   logic [AddrW-1:0]     sram_addr_c;
   logic [DataWidth-1:0] sram_wdata_c;
   logic [BeW-1:0]       sram_be_c;
   logic [DataWidth-1:0] sram_rdata;

   // Round-robin arbiter: first requester at or after the pointer wins, only in IDLE
   always_comb begin
      gnt_o    = '0;
      sel_c    = '0;
      cand_c   = '0;
      accept_c = 1'b0;
      if (state_q == StIdle) begin
         for (int k = 0; k < NumPorts; k++) begin
            cand_c = PtrW'((int'(ptr_q) + k) % int'(NumPorts));
            for (int p = 0; p < NumPorts; p++) begin
               if (!accept_c && (PtrW'(p) == cand_c) && req_i[p]) begin
                  gnt_o[p] = 1'b1;
                  sel_c    = cand_c;
                  accept_c = 1'b1;
               end
            end
         end
      end
   end

   // Payload mux of the winning port, overridden by the sweep write during INIT
   always_comb begin
      sel_we_c    = 1'b0;
      sel_addr_c  = '0;
      sel_wdata_c = '0;
      sel_be_c    = '0;
      for (int p = 0; p < NumPorts; p++) begin
         if (PtrW'(p) == sel_c) begin
            sel_we_c    = we_i[p];
            sel_addr_c  = addr_i[p*AddrW +: AddrW];
            sel_wdata_c = wdata_i[p*DataWidth +: DataWidth];
            sel_be_c    = be_i[p*BeW +: BeW];
         end
      end
      sram_req_c   = accept_c;
      sram_we_c    = sel_we_c;
      sram_addr_c  = sel_addr_c;
      sram_wdata_c = sel_wdata_c;
      sram_be_c    = sel_be_c;
      if (state_q == StInit) begin
         sram_req_c   = 1'b1;
         sram_we_c    = 1'b1;
         sram_addr_c  = cnt_q;
         sram_wdata_c = InitValue;
         sram_be_c    = '1;
      end
   end

   // Next state: sweep counter, flush restart and arbitration pointer
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         StInit: begin
            if (flush_i) begin
               cnt_d = '0;
            end else if (cnt_q == AddrW'(NumWords - 1)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AddrW'(1);
            end
         end
         StIdle: begin
            if (flush_i) begin
               state_d = StInit;
               cnt_d   = '0;
            end
         end
         default: state_d = StInit;
      endcase
      if (accept_c) begin
         ptr_d = PtrW'((int'(sel_c) + 1) % int'(NumPorts));
      end
   end

   // Response pipeline tracks which port expects read data Latency cycles later
   always_comb begin
      resp_d[0].valid = accept_c;
      resp_d[0].read  = accept_c & ~sel_we_c;
      resp_d[0].port  = PortIdxW'(sel_c);
      for (int s = 1; s < Latency; s++) begin
         resp_d[s] = resp_q[s-1];
      end
   end

   // State registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StInit;
         cnt_q   <= '0;
         ptr_q   <= '0;
         for (int s = 0; s < Latency; s++) begin
            resp_q[s] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         for (int s = 0; s < Latency; s++) begin
            resp_q[s] <= resp_d[s];
         end
      end
   end

   // Output decode from registered state
   always_comb begin
      busy_o = (state_q == StInit);
      for (int p = 0; p < NumPorts; p++) begin
         rvalid_o[p] = resp_q[Latency-1].valid && resp_q[Latency-1].read
                       && (resp_q[Latency-1].port == PortIdxW'(p));
      end
   end

   assign rdata_o = {NumPorts{sram_rdata}};

   tc_sram #(
      .NumWords  (NumWords),
      .DataWidth (DataWidth),
      .NumPorts  (1),
      .Latency   (Latency)
   ) i_tag_sram (
      .clk_i   (clk_i),
      .req_i   (sram_req_c),
      .we_i    (sram_we_c),
      .addr_i  (sram_addr_c),
      .wdata_i (sram_wdata_c),
      .be_i    (sram_be_c),
      .rdata_o (sram_rdata)
   );

endmodule

// File: tb/tb_axi_llc_tag_sram_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_axi_llc_tag_sram_ctrl;

   localparam int NW  = 16;
   localparam int DW  = 32;
   localparam int NP  = 2;
   localparam int LAT = 3;
   localparam int AW  = 4;
   localparam int BW  = 4;
   localparam logic [DW-1:0] INIT = 32'h1234_5678;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             flush;
   logic             busy;
   logic [NP-1:0]    req, gnt, we, rvalid;
   logic [NP*AW-1:0] addr;
   logic [NP*DW-1:0] wdata, rdata;
   logic [NP*BW-1:0] be;

   axi_llc_tag_sram_ctrl #(
      .NumWords  (NW),
      .DataWidth (DW),
      .NumPorts  (NP),
      .Latency   (LAT),
      .InitValue (INIT)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .flush_i  (flush),
      .busy_o   (busy),
      .req_i    (req),
      .gnt_o    (gnt),
      .we_i     (we),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .be_i     (be),
      .rvalid_o (rvalid),
      .rdata_o  (rdata)
   );

   // Reference model state
   logic [DW-1:0] mdl_mem [NW];
   int            mdl_ptr;
   int            mdl_iaddr;
   bit            mdl_busy;
   bit            p_req   [NP];
   bit            p_we    [NP];
   logic [AW-1:0] p_addr  [NP];
   logic [DW-1:0] p_wdata [NP];
   logic [BW-1:0] p_be    [NP];

   typedef struct {
      int            due;
      int            port;
      logic [DW-1:0] data;
   } exp_t;
   exp_t rq[$];

   int            cyc;
   int            errors;
   int            checks;
   logic [DW-1:0] last_rdata [NP];
   logic [NP-1:0] obs_gnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         req[p]             = p_req[p];
         we[p]              = p_we[p];
         addr[p*AW +: AW]   = p_addr[p];
         wdata[p*DW +: DW]  = p_wdata[p];
         be[p*BW +: BW]     = p_be[p];
      end
   endtask

   task automatic issue(input int p, input bit w, input int a, input logic [DW-1:0] d,
                        input logic [BW-1:0] b);
      p_req[p]   = 1'b1;
      p_we[p]    = w;
      p_addr[p]  = AW'(a);
      p_wdata[p] = d;
      p_be[p]    = b;
   endtask

   // One clock cycle: check combinational outputs, advance model, check responses
   task automatic tick(input bit fl);
      int            g;
      logic [NP-1:0] eg;
      logic [NP-1:0] erv;
      logic [DW-1:0] ed [NP];
      flush = fl;
      drive();
      #1;
      g  = -1;
      eg = '0;
      if (!mdl_busy) begin
         for (int k = 0; k < NP; k++) begin
            int c = (mdl_ptr + k) % NP;
            if (g < 0 && p_req[c]) g = c;
         end
      end
      if (g >= 0) eg[g] = 1'b1;
      obs_gnt = gnt;
      chk("busy", 64'(busy), 64'(mdl_busy));
      chk("gnt", 64'(gnt), 64'(eg));
      if (mdl_busy) begin
         mdl_mem[mdl_iaddr] = INIT;
         if (fl) mdl_iaddr = 0;
         else if (mdl_iaddr == NW - 1) begin
            mdl_busy  = 1'b0;
            mdl_iaddr = 0;
         end else mdl_iaddr++;
      end else begin
         if (g >= 0) begin
            if (p_we[g]) begin
               for (int b = 0; b < BW; b++)
                  if (p_be[g][b]) mdl_mem[p_addr[g]][8*b +: 8] = p_wdata[g][8*b +: 8];
            end else begin
               rq.push_back('{cyc + LAT, g, mdl_mem[p_addr[g]]});
            end
            mdl_ptr  = (g + 1) % NP;
            p_req[g] = 1'b0;
         end
         if (fl) begin
            mdl_busy  = 1'b1;
            mdl_iaddr = 0;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      erv = '0;
      for (int i = rq.size() - 1; i >= 0; i--) begin
         if (rq[i].due == cyc) begin
            erv[rq[i].port] = 1'b1;
            ed[rq[i].port]  = rq[i].data;
            rq.delete(i);
         end
      end
      chk("rvalid", 64'(rvalid), 64'(erv));
      for (int p = 0; p < NP; p++) begin
         if (erv[p]) begin
            chk($sformatf("rdata%0d", p), 64'(rdata[p*DW +: DW]), 64'(ed[p]));
            last_rdata[p] = rdata[p*DW +: DW];
         end
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      flush = 1'b0;
      for (int p = 0; p < NP; p++) p_req[p] = 1'b0;
      drive();
      #1;
      chk("rst_busy", 64'(busy), 64'(1));
      chk("rst_gnt", 64'(gnt), 64'(0));
      chk("rst_rvalid", 64'(rvalid), 64'(0));
      mdl_busy  = 1'b1;
      mdl_iaddr = 0;
      mdl_ptr   = 0;
      rq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic count_busy(input string tag);
      int n = 0;
      while (busy === 1'b1 && n < 64) begin
         tick(1'b0);
         n++;
      end
      chk(tag, 64'(n), 64'(NW));
   endtask

   initial begin
      int            n;
      int            start;
      logic [DW-1:0] d;
      rst    = 1'b1;
      flush  = 1'b0;
      errors = 0;
      checks = 0;
      cyc    = 0;
      for (int p = 0; p < NP; p++) begin
         p_req[p]      = 1'b0;
         p_we[p]       = 1'b0;
         p_addr[p]     = '0;
         p_wdata[p]    = '0;
         p_be[p]       = '0;
         last_rdata[p] = '0;
      end
      drive();

      // Reset release: sweep length, then every entry reads back InitValue
      do_reset();
      count_busy("init_len");
      for (int a = 0; a < NW; a++) begin
         issue(a % NP, 1'b0, a, '0, '0);
         tick(1'b0);
      end
      repeat (LAT + 1) tick(1'b0);

      // Byte-enable merge
      issue(0, 1'b1, 5, 32'hFFFF_FFFF, 4'hF);
      tick(1'b0);
      issue(1, 1'b1, 5, 32'hDEAD_BEEF, 4'b0101);
      tick(1'b0);
      issue(0, 1'b0, 5, '0, '0);
      tick(1'b0);
      repeat (LAT + 1) tick(1'b0);
      chk("byte_mask", 64'(last_rdata[0]), 64'(32'hFFAD_FFEF));

      // Read-after-write in consecutive cycles, response latency
      d = $urandom;
      issue(1, 1'b1, 3, d, 4'hF);
      tick(1'b0);
      issue(0, 1'b0, 3, '0, '0);
      tick(1'b0);
      n = 0;
      while (rvalid[0] !== 1'b1 && n < 10) begin
         tick(1'b0);
         n++;
      end
      chk("raw_latency", 64'(n + 1), 64'(LAT));
      chk("raw_data", 64'(last_rdata[0]), 64'(d));
      repeat (LAT) tick(1'b0);

      // Both ports requesting continuously: grants alternate
      start = mdl_ptr;
      for (int i = 0; i < 8; i++) begin
         for (int p = 0; p < NP; p++)
            if (!p_req[p]) issue(p, 1'b0, $urandom_range(0, NW - 1), '0, '0);
         tick(1'b0);
         chk("alt_gnt", 64'(obs_gnt), 64'(1) << ((start + i) % NP));
      end
      for (int p = 0; p < NP; p++) p_req[p] = 1'b0;
      repeat (LAT + 1) tick(1'b0);

      // Read followed by flush: response still delivered, entries re-initialised
      last_rdata[0] = '0;
      issue(0, 1'b0, 5, '0, '0);
      tick(1'b0);
      tick(1'b1);
      count_busy("flush_len");
      chk("flush_rd", 64'(last_rdata[0]), 64'(32'hFFAD_FFEF));
      issue(1, 1'b0, 5, '0, '0);
      tick(1'b0);
      repeat (LAT + 1) tick(1'b0);
      chk("post_flush", 64'(last_rdata[1]), 64'(INIT));

      // Random traffic with occasional flushes
      for (int i = 0; i < 300; i++) begin
         for (int p = 0; p < NP; p++) begin
            if (!p_req[p] && $urandom_range(0, 3) != 0)
               issue(p, 1'($urandom_range(0, 1)), $urandom_range(0, NW - 1), $urandom,
                     BW'($urandom_range(0, 15)));
         end
         tick($urandom_range(0, 39) == 0);
      end
      repeat (40) tick(1'b0);

      // Reset one cycle after a read grant: response discarded, sweep restarts
      issue(1, 1'b0, 2, '0, '0);
      tick(1'b0);
      do_reset();
      count_busy("rst_sweep");
      issue(0, 1'b0, 0, '0, '0);
      tick(1'b0);
      issue(1, 1'b0, NW - 1, '0, '0);
      tick(1'b0);
      repeat (LAT + 1) tick(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
